hd44780_reader: RTL and testbench

HD44780_READER -- requirements
Module: hd44780_reader

---
 rtl/hd44780_pkg.sv | 31 +++
 rtl/hd44780_delay.sv | 29 ++
 rtl/hd44780_reader.sv | 171 +++++++++++++++++
 tb/tb_hd44780_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 reader/writer: state encoding, busy-flag
// position and default bus timing (in clk cycles).
package hd44780_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EHIGH,
        ST_EHOLD,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam int BF_BIT = 7;

    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_EPW_CYC   = 12;
    localparam int DEF_HOLD_CYC  = 2;
    localparam int DEF_GAP_CYC   = 25;
    localparam int DEF_POLL_MAX  = 255;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/hd44780_delay.sv
// Loadable down-counter; done_o is high once the loaded count has run out.
// Loading N-1 makes done_o appear on the Nth cycle after the load edge.
module hd44780_delay
    import hd44780_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/hd44780_reader.sv
// HD44780 read engine: busy-flag polling and data reads over an 8-bit bus,
// or a 4-bit bus (two E pulses per byte) when HD44780_NIBBLE_MODE_EN is defined.
module hd44780_reader
    import hd44780_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int EPW_CYC   = DEF_EPW_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int POLL_MAX  = DEF_POLL_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    input  logic [7:0] lcd_db_in,
    output logic       lcd_db_oe
);

    localparam int CW = $clog2(max4(SETUP_CYC, EPW_CYC, HOLD_CYC, GAP_CYC)) + 1;
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EPW_LD   = CW'(EPW_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
    localparam logic [15:0]   POLL_LIM = 16'(POLL_MAX);

    state_e        state_q, state_d;
    logic          req_ready_q, rsp_valid_q, rsp_timeout_q;
    logic [7:0]    rsp_data_q, byte_q;
    logic          lcd_rs_q, lcd_rw_q, lcd_e_q;
    logic          poll_q;
    logic [15:0]   reads_q;
    logic          accept, last_pulse;
    logic          dly_load, dly_done;
    logic [CW-1:0] dly_val;

`ifdef HD44780_NIBBLE_MODE_EN
    logic       nib_q;  // high while the second (low-nibble) pulse of a byte is in progress
    logic [3:0] db_low_unused;
    assign db_low_unused = lcd_db_in[3:0];
    assign last_pulse    = nib_q;
`else
    assign last_pulse = 1'b1;
`endif

    assign accept = req_valid && req_ready_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SETUP;
            ST_SETUP: if (dly_done) state_d = ST_EHIGH;
            ST_EHIGH: if (dly_done) state_d = ST_EHOLD;
            ST_EHOLD: begin
                if (dly_done) begin
                    if (!last_pulse || (poll_q && byte_q[BF_BIT] && reads_q < POLL_LIM))
                        state_d = ST_GAP;
                    else
                        state_d = ST_DONE;
                end
            end
            ST_GAP:   if (dly_done) state_d = ST_EHIGH;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Every timed state is entered from a different state, so a state change reloads the timer.
    always_comb begin
        dly_val = '0;
        case (state_d)
            ST_SETUP: dly_val = SETUP_LD;
            ST_EHIGH: dly_val = EPW_LD;
            ST_EHOLD: dly_val = HOLD_LD;
            ST_GAP:   dly_val = GAP_LD;
            default:  dly_val = '0;
        endcase
        dly_load = (state_d != state_q) && (state_d != ST_IDLE) && (state_d != ST_DONE);
    end

    hd44780_delay #(.W(CW)) u_delay (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (dly_load),
        .load_val_i (dly_val),
        .done_o     (dly_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= 8'h00;
            byte_q        <= 8'h00;
            lcd_rs_q      <= 1'b0;
            lcd_rw_q      <= 1'b0;
            lcd_e_q       <= 1'b0;
            poll_q        <= 1'b0;
            reads_q       <= 16'd0;
`ifdef HD44780_NIBBLE_MODE_EN
            nib_q         <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == ST_IDLE);
            lcd_e_q     <= (state_d == ST_EHIGH);
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        lcd_rs_q <= req_rs;
                        lcd_rw_q <= 1'b1;
                        poll_q   <= req_poll && !req_rs;
                        reads_q  <= 16'd0;
`ifdef HD44780_NIBBLE_MODE_EN
                        nib_q    <= 1'b0;
`endif
                    end
                end
                ST_EHIGH: begin
                    if (dly_done) begin
`ifdef HD44780_NIBBLE_MODE_EN
                        if (nib_q) begin
                            byte_q[3:0] <= lcd_db_in[7:4];
                            reads_q     <= reads_q + 16'd1;
                        end else begin
                            byte_q[7:4] <= lcd_db_in[7:4];
                        end
`else
                        byte_q  <= lcd_db_in;
                        reads_q <= reads_q + 16'd1;
`endif
                    end
                end
                ST_EHOLD: begin
`ifdef HD44780_NIBBLE_MODE_EN
                    if (dly_done) nib_q <= !nib_q;
`endif
                end
                ST_DONE: begin
                    rsp_valid_q   <= 1'b1;
                    rsp_data_q    <= byte_q;
                    rsp_timeout_q <= poll_q && byte_q[BF_BIT];
                    lcd_rs_q      <= 1'b0;
                    lcd_rw_q      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_rw      = lcd_rw_q;
    assign lcd_e       = lcd_e_q;
    assign lcd_db_oe   = 1'b0;

endmodule

// File: tb/tb_hd44780_reader.sv
// Directed bench for hd44780_reader: vector table of read/poll transactions
// plus reset-state and mid-pulse abort sequences.
module tb_hd44780_reader;

    localparam int SETUP = 2;
    localparam int EPW   = 4;
    localparam int HOLD  = 2;
    localparam int GAP   = 3;
    localparam int PMAX  = 4;

    // 8-bit mode: first-byte latency and extra cycles per additional poll read
    localparam int L1 = 1 + SETUP + EPW + HOLD;
    localparam int P1 = GAP + EPW + HOLD;
    // 4-bit mode: first-byte latency and extra cycles per additional polled byte
    localparam int NL = 1 + SETUP + 2 * EPW + 2 * HOLD + GAP;
    localparam int NP = 2 * (GAP + EPW + HOLD);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rs = 1'b0;
    logic       req_poll = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db_in = 8'h00;
    logic       lcd_db_oe;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hd44780_reader #(
        .SETUP_CYC (SETUP),
        .EPW_CYC   (EPW),
        .HOLD_CYC  (HOLD),
        .GAP_CYC   (GAP),
        .POLL_MAX  (PMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs      (req_rs),
        .req_poll    (req_poll),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_db_in   (lcd_db_in),
        .lcd_db_oe   (lcd_db_oe)
    );

    typedef struct {
        logic            rs;
        logic            poll;
        logic            hold_valid;  // keep req_valid high while busy
        logic [3:0][7:0] db;          // bus value per E pulse (last entry repeats)
        int              pulses;
        int              lat;
        logic [7:0]      data;
        logic            tmo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rs, input logic poll, input logic hv,
                                input logic [31:0] db, input int pulses, input int lat,
                                input logic [7:0] data, input logic tmo);
        vec_t v;
        v.rs = rs; v.poll = poll; v.hold_valid = hv; v.db = db;
        v.pulses = pulses; v.lat = lat; v.data = data; v.tmo = tmo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   lat, pulses, ehigh;
        logic prev_e, got, bad_bus, bad_oe;
        logic [7:0] held;
        lat = 0; pulses = 0; ehigh = 0; prev_e = 1'b0; got = 1'b0;
        bad_bus = 1'b0; bad_oe = 1'b0;
        lcd_db_in = v.db[0];
        req_rs    = v.rs;
        req_poll  = v.poll;
        req_valid = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ready_drop"}, {31'd0, req_ready}, 32'd0);
        if (!v.hold_valid) req_valid = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (lcd_e && !prev_e) begin
                lcd_db_in = v.db[(pulses < 4) ? pulses : 3];
                pulses++;
            end
            if (lcd_e) begin
                ehigh++;
                if (lcd_rs !== v.rs || lcd_rw !== 1'b1) bad_bus = 1'b1;
            end
            if (lcd_db_oe !== 1'b0) bad_oe = 1'b1;
            prev_e = lcd_e;
            if (rsp_valid) begin
                got = 1'b1;
                lat = c;
                req_valid = 1'b0;
                break;
            end
        end
        chk({tag, "_rsp_seen"}, {31'd0, got}, 32'd1);
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_pulses"}, pulses, v.pulses);
        chk({tag, "_ehigh_cycles"}, ehigh, v.pulses * EPW);
        chk({tag, "_data"}, {24'd0, rsp_data}, {24'd0, v.data});
        chk({tag, "_timeout"}, {31'd0, rsp_timeout}, {31'd0, v.tmo});
        chk({tag, "_bus_stable"}, {31'd0, bad_bus}, 32'd0);
        chk({tag, "_db_oe"}, {31'd0, bad_oe}, 32'd0);
        held = rsp_data;
        @(posedge clk); #1;
        chk({tag, "_rsp_one_cycle"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rw_idle"}, {30'd0, lcd_rw, lcd_rs}, 32'd0);
        chk({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_data_held"}, {24'd0, rsp_data}, {24'd0, held});
    endtask

    initial begin
`ifdef HD44780_NIBBLE_MODE_EN
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0000C030, 2, NL, 8'h3C, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h20100080, 4, NL + NP, 8'h12, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 32'hF0F0F0F0, 2 * PMAX, NL + (PMAX - 1) * NP, 8'hFF, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h00005070, 2, NL, 8'h75, 1'b0));
`else
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h000000A5, 1, L1, 8'hA5, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h00138080, 3, L1 + 2 * P1, 8'h13, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, PMAX, L1 + (PMAX - 1) * P1, 8'hFF, 1'b1));
        vecs.push_back(mk(1'b1, 1'b1, 1'b1, 32'h00000080, 1, L1, 8'h80, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h00000080, 1, L1, 8'h80, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000007F, 1, L1, 8'h7F, 1'b0));
`endif

        // Reset state while rst is held
        #1;
        chk("rst_lcd", {29'd0, lcd_e, lcd_rw, lcd_rs}, 32'd0);
        chk("rst_oe", {31'd0, lcd_db_oe}, 32'd0);
        chk("rst_rsp", {30'd0, rsp_valid, rsp_timeout}, 32'd0);
        chk("rst_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rel_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rel_ready_rise", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // Idle cycles keep the last response data
        repeat (5) @(posedge clk);
        #1;
        chk("idle_data_held", {24'd0, rsp_data}, {24'd0, vecs[vecs.size() - 1].data});

        // Abort a read while E is high
        begin
            logic seen_e, seen_rsp;
            seen_e = 1'b0;
            seen_rsp = 1'b0;
            lcd_db_in = 8'h5A;
            req_rs = 1'b1;
            req_poll = 1'b0;
            req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            for (int c = 0; c < 20 && !seen_e; c++) begin
                @(posedge clk); #1;
                if (lcd_e) seen_e = 1'b1;
            end
            chk("abort_e_seen", {31'd0, seen_e}, 32'd1);
            @(posedge clk); #2;
            rst = 1'b1;
            #1;
            chk("abort_e_low", {31'd0, lcd_e}, 32'd0);
            chk("abort_rsrw", {30'd0, lcd_rw, lcd_rs}, 32'd0);
            chk("abort_ready", {31'd0, req_ready}, 32'd0);
            chk("abort_data", {24'd0, rsp_data}, 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            chk("abort_ready_rise", {31'd0, req_ready}, 32'd1);
            for (int c = 0; c < 30; c++) begin
                @(posedge clk); #1;
                if (rsp_valid || lcd_e) seen_rsp = 1'b1;
            end
            chk("abort_no_rsp", {31'd0, seen_rsp}, 32'd0);
        end

        // Fresh read after the abort
        run_vec(mk(1'b1, 1'b0, 1'b0, 32'h3C3C3C3C, 1 + (L1 == NL ? 0 : 0), L1, 8'h3C, 1'b0), "post")
            ;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
